// File: rtl/fp_pkg.sv
// Shared constants for the FP back end: mode encoding, per-mode exponent
// limits, biases, fraction widths and default leading-one positions.
`define HALF_MODE 1'b1

package fp_pkg;

  localparam int SUM_W_DEF   = 52;
  localparam int EXP_W_DEF   = 8;
  localparam int LEAD_SP_DEF = 46;
  localparam int LEAD_HP_DEF = 20;
  localparam int TAG_W_DEF   = 4;

  localparam int FRAC_SP     = 23;
  localparam int FRAC_HP     = 10;
  localparam int EXP_W_HP    = 5;
  localparam int EXP_MAX_SP  = 255;
  localparam int EXP_MAX_HP  = 31;
  localparam int BIAS_SP     = 127;
  localparam int BIAS_HP     = 15;

  typedef enum logic {
    MODE_SINGLE = 1'b0,
    MODE_HALF   = 1'b1
  } fp_mode_e;

  // Position the normalized leading one must occupy for a given mode.
  function automatic int lead_pos(input logic mode, input int lead_sp, input int lead_hp);
    return (mode == `HALF_MODE) ? lead_hp : lead_sp;
  endfunction

endpackage

// File: rtl/lod_enc.sv
// Leading-one detector: index of the highest set bit plus an all-zero flag.
module lod_enc
  import fp_pkg::*;
#(
  parameter int W  = SUM_W_DEF,
  parameter int IW = $clog2(W)
) (
  input  logic [W-1:0]  vec,
  output logic [IW-1:0] idx,
  output logic          zero
);

  // Scan upward so the highest set bit wins.
  always_comb begin
    idx = {IW{1'b0}};
    for (int i = 0; i < W; i++) begin
      idx = vec[i] ? IW'(i) : idx;
    end
  end

  assign zero = ~|vec;

endmodule

// File: rtl/fp_norm_round_pack_pipe.sv
// Normalize / round-to-nearest-even / pack back end, three registered stages
// with a valid/ready handshake that stalls the whole pipe as one unit.
module fp_norm_round_pack_pipe
  import fp_pkg::*;
#(
  parameter int SUM_W   = SUM_W_DEF,
  parameter int EXP_W   = EXP_W_DEF,
  parameter int LEAD_SP = LEAD_SP_DEF,
  parameter int LEAD_HP = LEAD_HP_DEF,
  parameter int TAG_W   = TAG_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             calculate_mode,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             sum_sign,
  input  logic [SUM_W-1:0] sum_mag,
  input  logic [EXP_W-1:0] exp_in,
  input  logic [TAG_W-1:0] tag_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      result,
  output logic [TAG_W-1:0] tag_out,
  output logic             flag_ovf,
  output logic             flag_unf,
  output logic             flag_zero
);

  localparam int LW = $clog2(SUM_W);
  localparam int EW = EXP_W + 2;

  // ---------------------------------------------------------------- handshake
  logic adv_s;
  logic v3_r;

  assign adv_s     = ~(v3_r & ~out_ready);
  assign in_ready  = adv_s;
  assign out_valid = v3_r;

  // ---------------------------------------------------------------- stage 1
  logic [LW-1:0] lead_s;
  logic          zero_s;
  logic [LW-1:0] lpos_in_s;
  logic [EW-1:0] e_in_s;

  lod_enc #(.W(SUM_W), .IW(LW)) u_lod (
    .vec  (sum_mag),
    .idx  (lead_s),
    .zero (zero_s)
  );

  // Exponent adjusted by the distance between the detected and target leading one.
  always_comb begin
    lpos_in_s = LW'(lead_pos(calculate_mode, LEAD_SP, LEAD_HP));
    e_in_s    = {2'b00, exp_in} + EW'(lead_s) - EW'(lpos_in_s);
  end

  logic             v1_r;
  logic             mode1_r;
  logic             sign1_r;
  logic             zero1_r;
  logic [SUM_W-1:0] mag1_r;
  logic [LW-1:0]    lead1_r;
  logic [EW-1:0]    e1_r;
  logic [TAG_W-1:0] tag1_r;

  // Stage 1 register: capture the beat with its leading-one index and exponent.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_r    <= 1'b0;
      mode1_r <= 1'b0;
      sign1_r <= 1'b0;
      zero1_r <= 1'b0;
      mag1_r  <= {SUM_W{1'b0}};
      lead1_r <= {LW{1'b0}};
      e1_r    <= {EW{1'b0}};
      tag1_r  <= {TAG_W{1'b0}};
    end else if (adv_s) begin
      v1_r <= in_valid;
      if (in_valid) begin
        mode1_r <= calculate_mode;
        sign1_r <= sum_sign;
        zero1_r <= zero_s;
        mag1_r  <= sum_mag;
        lead1_r <= lead_s;
        e1_r    <= e_in_s;
        tag1_r  <= tag_in;
      end
    end
  end

  // ---------------------------------------------------------------- stage 2
  logic [LW-1:0]      lpos2_s;
  logic [LW-1:0]      sh_s;
  logic [SUM_W-1:0]   norm_s;
  logic               sticky_sh_s;
  logic [FRAC_SP-1:0] frac_s;
  logic               guard_s;
  logic               sticky_s;
  logic               unused_norm_s;

  // Barrel shift so the leading one sits at L, then slice fraction/guard/sticky.
  always_comb begin
    lpos2_s = LW'(lead_pos(mode1_r, LEAD_SP, LEAD_HP));
    if (lead1_r > lpos2_s) begin
      sh_s        = lead1_r - lpos2_s;
      norm_s      = mag1_r >> sh_s;
      sticky_sh_s = |(mag1_r & ~({SUM_W{1'b1}} << sh_s));
    end else begin
      sh_s        = lpos2_s - lead1_r;
      norm_s      = mag1_r << sh_s;
      sticky_sh_s = 1'b0;
    end
    if (mode1_r == `HALF_MODE) begin
      frac_s   = {{(FRAC_SP-FRAC_HP){1'b0}}, norm_s[LEAD_HP-1 -: FRAC_HP]};
      guard_s  = norm_s[LEAD_HP-FRAC_HP-1];
      sticky_s = (|norm_s[LEAD_HP-FRAC_HP-2:0]) | sticky_sh_s;
    end else begin
      frac_s   = norm_s[LEAD_SP-1 -: FRAC_SP];
      guard_s  = norm_s[LEAD_SP-FRAC_SP-1];
      sticky_s = (|norm_s[LEAD_SP-FRAC_SP-2:0]) | sticky_sh_s;
    end
  end

  // The hidden one and anything above it never reach the packed word.
  assign unused_norm_s = ^norm_s[SUM_W-1:LEAD_SP];

  logic               v2_r;
  logic               mode2_r;
  logic               sign2_r;
  logic               zero2_r;
  logic [EW-1:0]      e2_r;
  logic [TAG_W-1:0]   tag2_r;
  logic [FRAC_SP-1:0] frac2_r;
  logic               guard2_r;
  logic               sticky2_r;

  // Stage 2 register: normalized fields ready for rounding.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2_r      <= 1'b0;
      mode2_r   <= 1'b0;
      sign2_r   <= 1'b0;
      zero2_r   <= 1'b0;
      e2_r      <= {EW{1'b0}};
      tag2_r    <= {TAG_W{1'b0}};
      frac2_r   <= {FRAC_SP{1'b0}};
      guard2_r  <= 1'b0;
      sticky2_r <= 1'b0;
    end else if (adv_s) begin
      v2_r <= v1_r;
      if (v1_r) begin
        mode2_r   <= mode1_r;
        sign2_r   <= sign1_r;
        zero2_r   <= zero1_r;
        e2_r      <= e1_r;
        tag2_r    <= tag1_r;
        frac2_r   <= frac_s;
        guard2_r  <= guard_s;
        sticky2_r <= sticky_s;
      end
    end
  end

  // ---------------------------------------------------------------- stage 3
  logic               inc_s;
  logic [FRAC_SP:0]   frac_sum_s;
  logic               carry_s;
  logic [EW-1:0]      e_rnd_s;
  logic [EW-1:0]      emax_s;
  logic [31:0]        res_s;
  logic               ovf_s;
  logic               unf_s;

  // Round to nearest even, fold the fraction carry into the exponent, then
  // resolve zero / overflow / underflow before packing.
  always_comb begin
    inc_s      = guard2_r & (sticky2_r | frac2_r[0]);
    frac_sum_s = {1'b0, frac2_r} + {{FRAC_SP{1'b0}}, inc_s};
    carry_s    = (mode2_r == `HALF_MODE) ? frac_sum_s[FRAC_HP] : frac_sum_s[FRAC_SP];
    e_rnd_s    = e2_r + {{(EW-1){1'b0}}, carry_s};
    emax_s     = (mode2_r == `HALF_MODE) ? EW'(EXP_MAX_HP) : EW'(EXP_MAX_SP);
    res_s      = 32'h0000_0000;
    ovf_s      = 1'b0;
    unf_s      = 1'b0;
    if (zero2_r) begin
      res_s = 32'h0000_0000;
    end else if ((e_rnd_s[EW-1] == 1'b0) && (e_rnd_s >= emax_s)) begin
      ovf_s = 1'b1;
      if (mode2_r == `HALF_MODE) begin
        res_s = {16'h0000, sign2_r, {EXP_W_HP{1'b1}}, {FRAC_HP{1'b0}}};
      end else begin
        res_s = {sign2_r, {EXP_W{1'b1}}, {FRAC_SP{1'b0}}};
      end
    end else if ((e_rnd_s[EW-1] == 1'b1) || (e_rnd_s == {EW{1'b0}})) begin
      unf_s = 1'b1;
      if (mode2_r == `HALF_MODE) begin
        res_s = {16'h0000, sign2_r, 15'h0000};
      end else begin
        res_s = {sign2_r, 31'h0000_0000};
      end
    end else begin
      if (mode2_r == `HALF_MODE) begin
        res_s = {16'h0000, sign2_r, e_rnd_s[EXP_W_HP-1:0], frac_sum_s[FRAC_HP-1:0]};
      end else begin
        res_s = {sign2_r, e_rnd_s[EXP_W-1:0], frac_sum_s[FRAC_SP-1:0]};
      end
    end
  end

  logic [31:0]      result_r;
  logic [TAG_W-1:0] tag3_r;
  logic             ovf_r;
  logic             unf_r;
  logic             zero3_r;

  // Output register: holds its contents whenever downstream stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v3_r     <= 1'b0;
      result_r <= 32'h0000_0000;
      tag3_r   <= {TAG_W{1'b0}};
      ovf_r    <= 1'b0;
      unf_r    <= 1'b0;
      zero3_r  <= 1'b0;
    end else if (adv_s) begin
      v3_r <= v2_r;
      if (v2_r) begin
        result_r <= res_s;
        tag3_r   <= tag2_r;
        ovf_r    <= ovf_s;
        unf_r    <= unf_s;
        zero3_r  <= zero2_r;
      end
    end
  end

  assign result    = result_r;
  assign tag_out   = tag3_r;
  assign flag_ovf  = ovf_r;
  assign flag_unf  = unf_r;
  assign flag_zero = zero3_r;

endmodule

// File: tb/tb_fp_norm_round_pack_pipe.sv
// Directed bench for fp_norm_round_pack_pipe: hand-computed vectors,
// latency, rounding, exception cases, backpressure and mid-flight reset.
module tb_fp_norm_round_pack_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        calculate_mode;
  logic        in_valid;
  logic        in_ready;
  logic        sum_sign;
  logic [51:0] sum_mag;
  logic [7:0]  exp_in;
  logic [3:0]  tag_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic [3:0]  tag_out;
  logic        flag_ovf;
  logic        flag_unf;
  logic        flag_zero;

  int n_vec = 0;
  int n_err = 0;

  localparam logic SP = 1'b0;
  localparam logic HP = 1'b1;

  fp_norm_round_pack_pipe dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .calculate_mode (calculate_mode),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .sum_sign       (sum_sign),
    .sum_mag        (sum_mag),
    .exp_in         (exp_in),
    .tag_in         (tag_in),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .result         (result),
    .tag_out        (tag_out),
    .flag_ovf       (flag_ovf),
    .flag_unf       (flag_unf),
    .flag_zero      (flag_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic drive(input logic m, input logic s, input logic [51:0] mag,
                       input logic [7:0] e, input logic [3:0] t);
    calculate_mode = m;
    sum_sign       = s;
    sum_mag        = mag;
    exp_in         = e;
    tag_in         = t;
  endtask

  // One beat through an idle pipe: checks exact 3-cycle latency and all outputs.
  task automatic run_vec(input string name, input logic m, input logic s,
                         input logic [51:0] mag, input logic [7:0] e, input logic [3:0] t,
                         input logic [31:0] exp_res, input logic [2:0] exp_flags);
    @(negedge clk);
    drive(m, s, mag, e, t);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    #1;
    chk({name, " in_ready"}, in_ready, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    chk({name, " early1"}, out_valid, 1'b0);
    @(negedge clk);
    chk({name, " early2"}, out_valid, 1'b0);
    @(negedge clk);
    chk({name, " valid"}, out_valid, 1'b1);
    chk({name, " result"}, result, exp_res);
    chk({name, " tag"}, tag_out, t);
    chk({name, " flags"}, {flag_ovf, flag_unf, flag_zero}, exp_flags);
  endtask

  logic [31:0] bp_res  [6];
  logic [3:0]  bp_tag  [6];
  logic        bp_mode [6];
  logic [51:0] bp_mag  [6];
  logic [7:0]  bp_exp  [6];
  int          n_in;
  int          n_out;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drive(SP, 1'b0, 52'd0, 8'd0, 4'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("reset out_valid", out_valid, 1'b0);
    chk("reset result", result, 32'h0);
    chk("reset tag", tag_out, 4'h0);
    chk("reset flags", {flag_ovf, flag_unf, flag_zero}, 3'b000);
    chk("reset in_ready", in_ready, 1'b1);

    run_vec("one_sp",   SP, 1'b0, 52'd1 << 46, 8'd127, 4'h1, 32'h3F80_0000, 3'b000);
    run_vec("one_hp",   HP, 1'b0, 52'd1 << 20, 8'd15,  4'h2, 32'h0000_3C00, 3'b000);
    run_vec("two_sp",   SP, 1'b0, 52'd1 << 47, 8'd127, 4'h3, 32'h4000_0000, 3'b000);
    run_vec("tie_even", SP, 1'b0, (52'd1 << 46) | (52'd1 << 22), 8'd127, 4'h4,
            32'h3F80_0000, 3'b000);
    run_vec("tie_odd",  SP, 1'b0, (52'd1 << 46) | (52'd1 << 23) | (52'd1 << 22), 8'd127, 4'h5,
            32'h3F80_0002, 3'b000);
    run_vec("sticky_up", SP, 1'b0, (52'd1 << 46) | (52'd1 << 22) | 52'd1, 8'd127, 4'h6,
            32'h3F80_0001, 3'b000);
    run_vec("rnd_ovf",  SP, 1'b0, 52'h1FF_FFFF << 22, 8'd254, 4'h7, 32'h7F80_0000, 3'b100);
    run_vec("unf_hp",   HP, 1'b0, 52'd1 << 19, 8'd1, 4'h8, 32'h0000_0000, 3'b010);
    run_vec("zero",     SP, 1'b1, 52'd0, 8'd200, 4'h9, 32'h0000_0000, 3'b001);
    run_vec("lshift",   SP, 1'b1, 52'd1 << 30, 8'd143, 4'hA, 32'hBF80_0000, 3'b000);
    run_vec("hp_rnd",   HP, 1'b1, (52'd1 << 20) | (52'd1 << 10) | (52'd1 << 9), 8'd15, 4'hB,
            32'h0000_BC02, 3'b000);
    run_vec("hp_rsh",   HP, 1'b0, (52'd1 << 40) | (52'd1 << 29) | 52'd1, 8'd0, 4'hC,
            32'h0000_5001, 3'b000);
    run_vec("ovf_hp",   HP, 1'b0, 52'd1 << 20, 8'd31, 4'hD, 32'h0000_7C00, 3'b100);
    run_vec("unf_sp",   SP, 1'b1, 52'd1 << 46, 8'd0, 4'hE, 32'h8000_0000, 3'b010);

    // Backpressure: six mixed-mode beats, out_ready low for five cycles mid-stream.
    bp_mode[0] = SP; bp_mag[0] = 52'd1 << 46; bp_exp[0] = 8'd127; bp_tag[0] = 4'h9; bp_res[0] = 32'h3F80_0000;
    bp_mode[1] = HP; bp_mag[1] = 52'd1 << 20; bp_exp[1] = 8'd16;  bp_tag[1] = 4'h3; bp_res[1] = 32'h0000_4000;
    bp_mode[2] = SP; bp_mag[2] = 52'd1 << 46; bp_exp[2] = 8'd129; bp_tag[2] = 4'hC; bp_res[2] = 32'h4080_0000;
    bp_mode[3] = HP; bp_mag[3] = 52'd1 << 20; bp_exp[3] = 8'd18;  bp_tag[3] = 4'h5; bp_res[3] = 32'h0000_4800;
    bp_mode[4] = SP; bp_mag[4] = 52'd1 << 46; bp_exp[4] = 8'd131; bp_tag[4] = 4'hA; bp_res[4] = 32'h4180_0000;
    bp_mode[5] = HP; bp_mag[5] = 52'd1 << 20; bp_exp[5] = 8'd20;  bp_tag[5] = 4'h6; bp_res[5] = 32'h0000_5000;
    n_in  = 0;
    n_out = 0;
    for (int cyc = 0; cyc < 40 && n_out < 6; cyc++) begin
      @(negedge clk);
      out_ready = !(cyc >= 5 && cyc < 10);
      if (n_in < 6) begin
        drive(bp_mode[n_in], 1'b0, bp_mag[n_in], bp_exp[n_in], bp_tag[n_in]);
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (!out_ready) begin
        chk("bp stall in_ready", in_ready, 1'b0);
        chk("bp stall valid", out_valid, 1'b1);
        chk("bp stall result", result, bp_res[n_out]);
        chk("bp stall tag", tag_out, bp_tag[n_out]);
      end
      if (out_valid && out_ready) begin
        chk("bp result", result, bp_res[n_out]);
        chk("bp tag", tag_out, bp_tag[n_out]);
        n_out++;
      end
      if (in_valid && in_ready) begin
        n_in++;
      end
    end
    chk("bp all accepted", n_in, 6);
    chk("bp all emitted", n_out, 6);
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("bp no duplicate", out_valid, 1'b0);
      @(negedge clk);
    end

    // Reset with three beats in flight.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      drive(SP, 1'b0, 52'd1 << 46, 8'd127, 4'(k + 1));
      in_valid = 1'b1;
    end
    @(negedge clk);
    in_valid = 1'b0;
    chk("rst inflight valid", out_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("rst async valid", out_valid, 1'b0);
    chk("rst async result", result, 32'h0);
    chk("rst async tag", tag_out, 4'h0);
    chk("rst async flags", {flag_ovf, flag_unf, flag_zero}, 3'b000);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst release in_ready", in_ready, 1'b1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("rst no stale beat", out_valid, 1'b0);
    end

    run_vec("post_rst", SP, 1'b0, 52'd1 << 46, 8'd128, 4'hF, 32'h4000_0000, 3'b000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fp_norm_round_pack_pipe.md
Name: fp_norm_round_pack_pipe

Overview:
Final normalize/round/pack stage of the multi-precision FP datapath, the registered successor to the combinational back end. Takes a sign-magnitude accumulated sum plus a pre-normalization exponent. Performs leading-one detection, normalization, round-to-nearest-even with exponent carry, and overflow/underflow/zero handling. Emits packed single or half results through a 3-stage valid/ready pipeline with a tag sideband.

Parameters:
SUM_W, 52, width of the magnitude input
EXP_W, 8, internal/single exponent width
LEAD_SP, 46, bit position of the normalized leading one in single mode
LEAD_HP, 20, bit position of the normalized leading one in half mode
TAG_W, 4, opaque sideband carried alongside each result

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
calculate_mode  in  1  `half_mode` = half, otherwise single; sampled with in_valid
in_valid  in  1  input beat valid
in_ready  out  1  stage can accept a beat
sum_sign  in  1  result sign
sum_mag  in  SUM_W  unsigned magnitude
exp_in  in  EXP_W  biased exponent for a leading one at LEAD_x
tag_in  in  TAG_W  sideband
out_valid  out  1  result valid
out_ready  in  1  downstream accepts
result  out  32  packed; half mode = {16'b0, s, e[4:0], f[9:0]}
tag_out  out  TAG_W  sideband of result
flag_ovf  out  1  result saturated to infinity
flag_unf  out  1  result flushed to zero
flag_zero  out  1  sum_mag was zero

Behaviour:
- Reset: all stage valid bits 0; out_valid, result, tag_out and all flags 0; in_ready 1 after reset release. Reset mid-operation discards every in-flight beat.
- Pipeline: S1 = LOD plus exponent-adjust compute; S2 = barrel normalize and G/S extraction; S3 = round and pack (output registers). Latency is 3 cycles from an accepted beat to out_valid.
- Handshake: a beat transfers when valid & ready. stall = out_valid & ~out_ready; the whole pipe holds when stall is 1. in_ready = ~stall. Outputs stay stable while stalled. Order is preserved. No bubbles are inserted when out_ready stays 1.
- LOD: lead = index of the highest set bit of sum_mag. L = LEAD_SP or LEAD_HP per mode.
- Exponent: e = exp_in + (lead - L), computed signed in EXP_W+2 bits.
- Normalize: shift right by lead-L if lead > L, else left by L-lead, so the leading one lands on bit L. Bits shifted out on the right are ORed into sticky.
- Fields: single mode takes frac = bits [L-1:L-23], guard = bit L-24, sticky = |bits [L-25:0] | shifted-out bits. Half mode uses 10 fraction bits with the same layout relative to L.
- RNE: increment when guard & (sticky | frac_lsb). A carry out of frac sets frac = 0 and e = e+1.
- Overflow: if e ≥ 255 (single) or e ≥ 31 (half) after rounding, the result is {sign, all-ones exponent, 0 fraction} and flag_ovf = 1.
- Underflow: if e ≤ 0, the result is signed zero and flag_unf = 1. Denormals are not produced.
- Zero: if sum_mag == 0, the result is +0 and flag_zero = 1; exponent and rounding logic are ignored.
- calculate_mode travels with its beat. Back-to-back beats with mixed modes are legal.

Decomposition:
- Shared package fp_pkg: `half_mode` define, per-mode EXP_MAX, bias, and fraction widths, and LEAD_SP/LEAD_HP defaults.
- One sub-module lod_enc (priority encoder of SUM_W bits to index plus a zero flag), instantiated in S1.

Test Plan:
- Single, sum_mag = 1<<46, exp_in = 127, sign 0 -> result 0x3F800000 after 3 cycles, all flags 0.
- Half, sum_mag = 1<<20, exp_in = 15 -> result 0x00003C00. Single, sum_mag = 1<<47, exp_in = 127 -> 0x40000000.
- RNE tie: single, bits 46 and 22 set -> 0x3F800000 (tie to even). Bits 46, 23 and 22 set -> 0x3F800002. Bits 46, 22 and 0 set -> 0x3F800001.
- Round carry plus overflow: single, bits 46:22 all set, exp_in = 254 -> 0x7F800000, flag_ovf = 1. Half, exp_in = 1, sum_mag = 1<<19 -> 0x00000000, flag_unf = 1.
- Backpressure: stream 6 beats with distinct tags, hold out_ready = 0 for 5 cycles mid-stream -> in_ready low while stalled, outputs held stable, all 6 results emitted in order with no loss or duplication.
- Zero input and reset: sum_mag = 0, sign 1 -> result 0x00000000, flag_zero = 1. Assert rst_n low with 3 beats in flight -> out_valid 0 immediately and no stale beat after release.
